// File: rtl/input_event_decoder.sv
// Debounces the starter-board buttons and filters the rotary encoder into event codes, which are
// arbitrated and queued in a show-ahead FIFO. Define INPUT_ROTARY_EN to build the rotary filter.
module input_event_decoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       BTN_NORTH,
  input  logic       BTN_SOUTH,
  input  logic       BTN_EAST,
  input  logic       BTN_WEST,
  input  logic       ROT_CENTER,
  input  logic       ROT_A,
  input  logic       ROT_B,
  input  logic       iEventRead,
  input  logic       iClearOverflow,
  output logic       oEventValid,
  output logic [3:0] oEventCode,
  output logic       oOverflow
);

  localparam int NBTN  = 5;
  localparam int NCODE = 7;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW-1:0]    PTR_ZERO   = AW'(0);
  localparam logic [AW-1:0]    PTR_ONE    = AW'(1);
  localparam logic [CW-1:0]    COUNT_ZERO = CW'(0);
  localparam logic [CW-1:0]    COUNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    DEPTH      = CW'(FIFO_DEPTH);

  // Map a one-hot grant (bit 0 = code 1) onto its 3-bit event code
  function automatic logic [2:0] grant_code(input logic [NCODE-1:0] oh);
    case (oh)
      7'b000_0001: grant_code = 3'd1;
      7'b000_0010: grant_code = 3'd2;
      7'b000_0100: grant_code = 3'd3;
      7'b000_1000: grant_code = 3'd4;
      7'b001_0000: grant_code = 3'd5;
      7'b010_0000: grant_code = 3'd6;
      7'b100_0000: grant_code = 3'd7;
      default:     grant_code = 3'd0;
    endcase
  endfunction

  logic [NBTN-1:0]  btn_raw_s;
  logic [NBTN-1:0]  btn_meta_r;
  logic [NBTN-1:0]  btn_sync_r;
  logic [NBTN-1:0]  stable_r;
  logic [NBTN-1:0]  press_r;
  logic [CNT_W-1:0] cnt_r [NBTN];

  logic [1:0]       rot_ev_s;
  logic [NCODE-1:0] ev_s;
  logic [NCODE-1:0] pending_r;
  logic [NCODE-1:0] pending_next_s;
  logic [NCODE-1:0] grant_s;
  logic [2:0]       push_code_s;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             wr_en_s;
  logic             ev_drop_s;
  logic             fifo_drop_s;
  logic             ovf_set_s;

  logic [2:0]       mem_r [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             ovf_r;

  // Bit i of the button vector corresponds to event code i+1
  assign btn_raw_s = {ROT_CENTER, BTN_WEST, BTN_EAST, BTN_SOUTH, BTN_NORTH};

  // Two-stage synchronizers for the raw buttons
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      btn_meta_r <= {NBTN{1'b0}};
      btn_sync_r <= {NBTN{1'b0}};
    end else begin
      btn_meta_r <= btn_raw_s;
      btn_sync_r <= btn_meta_r;
    end
  end

  // Debounce counters, stable levels and one-cycle press strobes
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NBTN; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
      stable_r <= {NBTN{1'b0}};
      press_r  <= {NBTN{1'b0}};
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        if (btn_sync_r[i] == stable_r[i]) begin
          cnt_r[i]   <= CNT_ZERO;
          press_r[i] <= 1'b0;
        end else if (cnt_r[i] == CNT_LAST) begin
          // The level has disagreed for a full debounce window: accept it
          stable_r[i] <= btn_sync_r[i];
          cnt_r[i]    <= CNT_ZERO;
          press_r[i]  <= btn_sync_r[i];
        end else begin
          cnt_r[i]   <= cnt_r[i] + CNT_ONE;
          press_r[i] <= 1'b0;
        end
      end
    end
  end

`ifdef INPUT_ROTARY_EN
  logic [1:0] rot_meta_r;
  logic [1:0] rot_sync_r;
  logic       q1_r;
  logic       q1_d_r;
  logic       q2_r;

  // Rotary synchronizers and quadrature filter; rot_sync_r is {B, A}
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rot_meta_r <= 2'b00;
      rot_sync_r <= 2'b00;
      q1_r       <= 1'b0;
      q1_d_r     <= 1'b0;
      q2_r       <= 1'b0;
    end else begin
      rot_meta_r <= {ROT_B, ROT_A};
      rot_sync_r <= rot_meta_r;
      q1_d_r     <= q1_r;
      case (rot_sync_r)
        2'b11:   q1_r <= 1'b1;
        2'b00:   q1_r <= 1'b0;
        2'b10:   q2_r <= 1'b1;
        2'b01:   q2_r <= 1'b0;
        default: q1_r <= q1_r;
      endcase
    end
  end

  // A q1 rising edge is one detent; q2 gives the direction (bit 1 = CCW, bit 0 = CW)
  assign rot_ev_s = {q1_r & ~q1_d_r & q2_r, q1_r & ~q1_d_r & ~q2_r};
`else
  logic unused_rot_s;

  assign unused_rot_s = ROT_A ^ ROT_B;
  assign rot_ev_s     = 2'b00;
`endif

  assign ev_s = {rot_ev_s, press_r};

  // Lowest-code arbitration, pending-flag next state, FIFO handshake and drop detection
  always_comb begin
    grant_s        = pending_r & (~pending_r + 7'b000_0001);
    push_s         = |pending_r;
    push_code_s    = grant_code(grant_s);
    ev_drop_s      = |(ev_s & pending_r);
    pending_next_s = (pending_r & ~grant_s) | (ev_s & ~pending_r);
    pop_s          = iEventRead & (count_r != COUNT_ZERO);
    full_s         = (count_r == DEPTH);
    wr_en_s        = push_s & (~full_s | pop_s);
    fifo_drop_s    = push_s & full_s & ~pop_s;
    ovf_set_s      = ev_drop_s | fifo_drop_s;
  end

  // Pending flags and the sticky overflow flag (a new drop beats a clear)
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pending_r <= {NCODE{1'b0}};
      ovf_r     <= 1'b0;
    end else begin
      pending_r <= pending_next_s;
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (iClearOverflow) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

  // FIFO storage, pointers and occupancy; pointers wrap naturally at the power-of-2 depth
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 3'd0;
      end
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= COUNT_ZERO;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= push_code_s;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + COUNT_ONE;
        2'b01:   count_r <= count_r - COUNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign oEventValid = (count_r != COUNT_ZERO);
  assign oEventCode  = oEventValid ? {1'b0, mem_r[rd_ptr_r]} : 4'b0000;
  assign oOverflow   = ovf_r;

endmodule

// File: tb/tb_input_event_decoder.sv
// Self-checking bench for input_event_decoder: directed table, hand sequences and a randomized
// run against an event-level reference model. Rotary expectations follow INPUT_ROTARY_EN.
module tb_input_event_decoder;

  localparam int D     = 4;
  localparam int DEPTH = 4;
`ifdef INPUT_ROTARY_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic       Clock = 1'b0;
  logic       Reset;
  logic [4:0] btn;
  logic       rot_a, rot_b, rd, clr;
  logic       oEventValid;
  logic [3:0] oEventCode;
  logic       oOverflow;

  int checks   = 0;
  int failures = 0;

  input_event_decoder #(.DEBOUNCE_CYCLES(D), .CNT_W(3), .FIFO_DEPTH(DEPTH)) dut (
    .Clock(Clock), .Reset(Reset),
    .BTN_NORTH(btn[0]), .BTN_SOUTH(btn[1]), .BTN_EAST(btn[2]), .BTN_WEST(btn[3]),
    .ROT_CENTER(btn[4]), .ROT_A(rot_a), .ROT_B(rot_b),
    .iEventRead(rd), .iClearOverflow(clr),
    .oEventValid(oEventValid), .oEventCode(oEventCode), .oOverflow(oOverflow)
  );

  always #5 Clock = ~Clock;

  // ---------------- reference model (event level) ----------------
  bit [6:0] m_d1, m_d2;        // raw samples taken at the last edge and the one before
  int       m_run [5];         // consecutive samples disagreeing with the accepted level
  bit [4:0] m_lvl, m_press;
  bit       m_q1, m_q2, m_rot_new;
  int       m_rot_code;
  bit [7:1] m_pend;
  int       m_fifo [$];
  bit       m_ovf;

  function automatic void model_reset();
    m_d1 = '0; m_d2 = '0; m_lvl = '0; m_press = '0;
    for (int i = 0; i < 5; i++) m_run[i] = 0;
    m_q1 = 0; m_q2 = 0; m_rot_new = 0; m_rot_code = 0;
    m_pend = '0; m_fifo.delete(); m_ovf = 0;
  endfunction

  function automatic void model_edge();
    bit [7:1] pend_pre, ev;
    bit       drop, old_q1, a, b;
    bit [6:0] sync;
    int       g;
    pend_pre = m_pend;
    drop = 0;
    g = 0;
    for (int c = 1; c <= 7; c++) if (g == 0 && pend_pre[c]) g = c;
    if (rd && m_fifo.size() > 0) void'(m_fifo.pop_front());
    if (g != 0) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(g);
      else drop = 1;
      m_pend[g] = 0;
    end
    ev = '0;
    for (int i = 0; i < 5; i++) if (m_press[i]) ev[i+1] = 1;
    if (m_rot_new) ev[m_rot_code] = 1;
    for (int c = 1; c <= 7; c++) begin
      if (ev[c] && pend_pre[c]) drop = 1;
      else if (ev[c]) m_pend[c] = 1;
    end
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
    sync = m_d2;
    for (int i = 0; i < 5; i++) begin
      m_press[i] = 0;
      if (sync[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_lvl[i] = sync[i];
          m_run[i] = 0;
          m_press[i] = sync[i];
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_rot_new = 0;
    if (ROT_EN) begin
      a = sync[5]; b = sync[6];
      old_q1 = m_q1;
      if (a && b) m_q1 = 1;
      else if (!a && !b) m_q1 = 0;
      if (!a && b) m_q2 = 1;
      else if (a && !b) m_q2 = 0;
      m_rot_new  = !old_q1 && m_q1;
      m_rot_code = m_q2 ? 7 : 6;
    end
    m_d2 = m_d1;
    m_d1 = {rot_b, rot_a, btn};
  endfunction

  task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic check_model();
    check_val("mdl_valid", 32'(oEventValid), 32'(m_fifo.size() != 0));
    check_val("mdl_code", 32'(oEventCode), (m_fifo.size() != 0) ? 32'(m_fifo[0]) : 32'd0);
    check_val("mdl_ovf", 32'(oOverflow), 32'(m_ovf));
  endtask

  task automatic tick();
    @(posedge Clock);
    if (Reset) model_reset();
    else model_edge();
    #1;
    check_model();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [4:0] btn;
    bit         rd;
    bit         clr;
    int         cyc;
    bit         ev;
    logic [3:0] ec;
    bit         eo;
    string      nm;
  } vec_t;

  function automatic vec_t mk(logic [4:0] b, bit r, bit c, int n, bit v, logic [3:0] e,
                              bit o, string nm);
    vec_t t;
    t.btn = b; t.rd = r; t.clr = c; t.cyc = n; t.ev = v; t.ec = e; t.eo = o; t.nm = nm;
    return t;
  endfunction

  vec_t tbl [$];

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; btn = 5'b00001; rot_a = 0; rot_b = 0; rd = 0; clr = 0;
    model_reset();

    tbl.push_back(mk(5'b00000, 1, 0, 2,  0, 4'd0, 0, "empty_pop"));
    tbl.push_back(mk(5'b11000, 0, 0, 7,  0, 4'd0, 0, "simul_wait"));
    tbl.push_back(mk(5'b11000, 0, 0, 1,  1, 4'd4, 0, "simul_first"));
    tbl.push_back(mk(5'b11000, 0, 0, 1,  1, 4'd4, 0, "simul_second"));
    tbl.push_back(mk(5'b11000, 1, 0, 1,  1, 4'd5, 0, "simul_pop1"));
    tbl.push_back(mk(5'b11000, 1, 0, 1,  0, 4'd0, 0, "simul_pop2"));
    tbl.push_back(mk(5'b00000, 0, 0, 10, 0, 4'd0, 0, "simul_release"));
    tbl.push_back(mk(5'b11111, 0, 0, 7,  0, 4'd0, 0, "ovf_wait"));
    tbl.push_back(mk(5'b11111, 0, 0, 4,  1, 4'd1, 0, "ovf_fill"));
    tbl.push_back(mk(5'b11111, 0, 0, 1,  1, 4'd1, 1, "ovf_drop"));
    tbl.push_back(mk(5'b11111, 0, 1, 1,  1, 4'd1, 0, "ovf_clear"));
    tbl.push_back(mk(5'b00000, 0, 0, 8,  1, 4'd1, 0, "ovf_release"));
    tbl.push_back(mk(5'b00001, 0, 0, 7,  1, 4'd1, 0, "full_wait"));
    tbl.push_back(mk(5'b00001, 1, 0, 1,  1, 4'd2, 0, "full_pushpop"));
    tbl.push_back(mk(5'b00001, 1, 0, 1,  1, 4'd3, 0, "drain1"));
    tbl.push_back(mk(5'b00001, 1, 0, 1,  1, 4'd4, 0, "drain2"));
    tbl.push_back(mk(5'b00001, 1, 0, 1,  1, 4'd1, 0, "drain3"));
    tbl.push_back(mk(5'b00001, 1, 0, 1,  0, 4'd0, 0, "drain4"));
    tbl.push_back(mk(5'b00000, 0, 0, 10, 0, 4'd0, 0, "final_release"));

    // reset held with NORTH pressed, then exact press latency
    repeat (3) tick();
    check_val("reset_valid", 32'(oEventValid), 32'd0);
    check_val("reset_code", 32'(oEventCode), 32'd0);
    check_val("reset_ovf", 32'(oOverflow), 32'd0);
    Reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_val("rst_latency", 32'(oEventValid), 32'(k == 8));
    end
    check_val("rst_code", 32'(oEventCode), 32'd1);
    rd = 1; tick(); rd = 0;
    btn = 5'b00000;
    repeat (10) tick();
    check_val("rst_single", 32'(oEventValid), 32'd0);

    // bounce rejection on EAST
    for (int r = 0; r < 4; r++) begin
      btn[2] = 1; repeat (3) tick();
      btn[2] = 0; repeat (3) tick();
    end
    check_val("bounce_none", 32'(oEventValid), 32'd0);
    btn[2] = 1;
    repeat (8) tick();
    check_val("bounce_hold_v", 32'(oEventValid), 32'd1);
    check_val("bounce_hold_c", 32'(oEventCode), 32'd3);
    rd = 1; tick(); rd = 0;
    check_val("bounce_single", 32'(oEventValid), 32'd0);
    btn[2] = 0;
    repeat (10) tick();
    check_val("bounce_release", 32'(oEventValid), 32'd0);

    // table-driven vectors
    foreach (tbl[i]) begin
      btn = tbl[i].btn; rd = tbl[i].rd; clr = tbl[i].clr;
      repeat (tbl[i].cyc) tick();
      check_val({tbl[i].nm, "_valid"}, 32'(oEventValid), 32'(tbl[i].ev));
      check_val({tbl[i].nm, "_code"}, 32'(oEventCode), 32'(tbl[i].ec));
      check_val({tbl[i].nm, "_ovf"}, 32'(oOverflow), 32'(tbl[i].eo));
    end
    rd = 0; clr = 0; btn = 5'b00000;

    // rotary: (0,0)->(0,1)->(1,1) gives CCW, (0,0)->(1,0)->(1,1) gives CW, at edge 5
    rot_a = 0; rot_b = 1; repeat (4) tick();
    rot_a = 1; rot_b = 1; repeat (4) tick();
    check_val("rot_ccw_early", 32'(oEventValid), 32'd0);
    tick();
    check_val("rot_ccw_valid", 32'(oEventValid), 32'(ROT_EN));
    check_val("rot_ccw_code", 32'(oEventCode), ROT_EN ? 32'd7 : 32'd0);
    rd = 1; tick(); rd = 0;
    rot_a = 0; rot_b = 0; repeat (4) tick();
    rot_a = 1; rot_b = 0; repeat (4) tick();
    rot_a = 1; rot_b = 1; repeat (4) tick();
    check_val("rot_cw_early", 32'(oEventValid), 32'd0);
    tick();
    check_val("rot_cw_valid", 32'(oEventValid), 32'(ROT_EN));
    check_val("rot_cw_code", 32'(oEventCode), ROT_EN ? 32'd6 : 32'd0);
    rd = 1; tick(); rd = 0;

    // randomized run against the model, with one asynchronous mid-cycle reset
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 5; i++) begin
        if ($urandom_range(0, 15) == 0) btn[i] = ~btn[i];
      end
      if ($urandom_range(0, 3) == 0) begin
        rot_a = 1'($urandom_range(0, 1));
        rot_b = 1'($urandom_range(0, 1));
      end
      rd  = ($urandom_range(0, 3) < ((n < 2000) ? 1 : 3));
      clr = ($urandom_range(0, 19) == 0);
      if (n == 2000) begin
        #3;
        Reset = 1'b1;
        #1;
        check_val("async_rst_valid", 32'(oEventValid), 32'd0);
        check_val("async_rst_code", 32'(oEventCode), 32'd0);
        check_val("async_rst_ovf", 32'(oOverflow), 32'd0);
        model_reset();
        repeat (2) tick();
        Reset = 1'b0;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
